// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, loader header bytes and loader state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = AES_BLOCK_W / 8;

    localparam logic [7:0] HDR_ENC       = 8'hA4;
    localparam logic [7:0] HDR_DEC       = 8'hA5;
    localparam logic [7:0] HDR_ENC_REUSE = 8'hA6;
    localparam logic [7:0] HDR_DEC_REUSE = 8'hA7;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_KEY,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT
    } loader_state_e;

endpackage

// File: rtl/aes_byte_shreg128.sv
// 128-bit byte-wide shift register: each enabled cycle shifts left by one byte and
// appends in_byte, so the first byte of a 16-byte field lands in [127:120].
module aes_byte_shreg128
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [7:0]             in_byte,
    output logic [AES_BLOCK_W-1:0] q
);

    logic [AES_BLOCK_W-1:0] shreg_q;
    logic [AES_BLOCK_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_en) begin
            shreg_d = {shreg_q[AES_BLOCK_W-9:0], in_byte};
        end
    end

    // NOTE: this storage is reset on purpose -- key/block are visible outputs that must read
    // zero after reset; a plain data RAM would normally be left without reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q = shreg_q;

endmodule

// File: rtl/aes_block_loader.sv
// Byte-stream loader for an AES core: header, 16 key bytes, 16 data bytes, one start pulse.
// Optional AES_LOADER_KEY_REUSE_EN adds headers that skip the key field and reuse the held key.
module aes_block_loader
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [AES_BLOCK_W-1:0] key,
    output logic [AES_BLOCK_W-1:0] block,
    output logic                   mode_dec,
    output logic                   start,
    input  logic                   core_done,
    output logic                   busy,
    output logic                   err
);

    loader_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          mode_dec_q, mode_dec_d;
    logic          err_q, err_d;
    logic          key_shift;
    logic          blk_shift;
    logic          fire;
`ifdef AES_LOADER_KEY_REUSE_EN
    logic          key_valid_q, key_valid_d;
`endif

    assign in_ready = !reset && (state_q == ST_HDR || state_q == ST_KEY || state_q == ST_DATA);
    assign fire     = in_valid && in_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_dec_d = mode_dec_q;
        err_d      = err_q;
        key_shift  = 1'b0;
        blk_shift  = 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
        key_valid_d = key_valid_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (fire) begin
                    case (in_byte)
                        HDR_ENC, HDR_DEC: begin
                            mode_dec_d = in_byte[0];
                            state_d    = ST_KEY;
                        end
`ifdef AES_LOADER_KEY_REUSE_EN
                        HDR_ENC_REUSE, HDR_DEC_REUSE: begin
                            if (key_valid_q) begin
                                mode_dec_d = in_byte[0];
                                state_d    = ST_DATA;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_KEY: begin
                if (fire) begin
                    key_shift = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_DATA;
`ifdef AES_LOADER_KEY_REUSE_EN
                        key_valid_d = 1'b1;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    blk_shift = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HDR;
            cnt_q      <= 4'd0;
            mode_dec_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_dec_q <= mode_dec_d;
            err_q      <= err_d;
`ifdef AES_LOADER_KEY_REUSE_EN
            key_valid_q <= key_valid_d;
`endif
        end
    end

    aes_byte_shreg128 u_key_reg (
        .clk     (clk),
        .reset   (reset),
        .load_en (key_shift),
        .in_byte (in_byte),
        .q       (key)
    );

    aes_byte_shreg128 u_block_reg (
        .clk     (clk),
        .reset   (reset),
        .load_en (blk_shift),
        .in_byte (in_byte),
        .q       (block)
    );

    assign mode_dec = mode_dec_q;
    assign err      = err_q;
    assign start    = (state_q == ST_ISSUE);
    assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a start-pulse scoreboard.
// Optional AES_LOADER_KEY_REUSE_EN selects the key-reuse scenario.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] block;
    logic         mode_dec;
    logic         start;
    logic         core_done = 1'b0;
    logic         busy;
    logic         err;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] blk;
        logic         mode;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DAT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] DAT_B = 128'h3243f6a8885a308d313198a2e0370734;

    aes_block_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .block     (block),
        .mode_dec  (mode_dec),
        .start     (start),
        .core_done (core_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every start pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            exp_t e;
            start_cnt++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL stray_start: observed start with no expected request, expected none");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_key", key, e.key);
                check("sb_block", block, e.blk);
                check("sb_mode_dec", mode_dec, e.mode);
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        core_done = 1'b0;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (in_ready === 1'b1) else begin
            miscompares++;
            $error("FAIL ready_timeout: observed in_ready %b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [7:0] hdr, input int max_gap, input bit send_key,
                           input logic [127:0] k, input logic [127:0] d,
                           input logic [127:0] exp_key, input logic exp_mode);
        sb.push_back('{exp_key, d, exp_mode});
        send_byte(hdr, $urandom_range(0, max_gap));
        if (send_key) begin
            for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], $urandom_range(0, max_gap));
        end
        for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8], $urandom_range(0, max_gap));
    endtask

    // Called right after the last data byte is accepted: start must appear on the very next cycle.
    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, 0);
        check("busy_in_issue", busy, 1'b1);
        check("in_ready_in_issue", in_ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_core();
        core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
        @(negedge clk);
        check("idle_after_done", busy, 1'b0);
        check("ready_after_done", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_key", key, '0);
        check("rst_block", block, '0);
        check("rst_mode_dec", mode_dec, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Encrypt, back-to-back bytes
        s0 = start_cnt;
        run_seq(8'hA4, 0, 1'b1, KEY_A, DAT_A, KEY_A, 1'b0);
        wait_start();
        check("wait_start_low", start, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("busy_in_wait", busy, 1'b1);
            check("ready_in_wait", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        release_core();
        check("enc_key", key, 128'h000102030405060708090a0b0c0d0e0f);
        check("enc_block", block, 128'h00112233445566778899aabbccddeeff);
        check("enc_mode", mode_dec, 1'b0);
        check("enc_one_start", start_cnt - s0, 1);

        // Decrypt with random in_valid gaps
        s0 = start_cnt;
        run_seq(8'hA5, 3, 1'b1, KEY_A, DAT_A, KEY_A, 1'b1);
        wait_start();
        release_core();
        check("dec_mode", mode_dec, 1'b1);
        check("dec_key", key, KEY_A);
        check("dec_one_start", start_cnt - s0, 1);

        // Bad header then a normal sequence; err stays sticky
        send_byte(8'h3C, 0);
        @(negedge clk);
        check("bad_hdr_err", err, 1'b1);
        check("bad_hdr_ready", in_ready, 1'b1);
        check("bad_hdr_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        run_seq(8'hA4, 1, 1'b1, KEY_B, DAT_B, KEY_B, 1'b0);
        wait_start();
        release_core();
        check("err_sticky", err, 1'b1);

        // core_done outside WAIT is ignored
        do_reset();
        core_done = 1'b1;
        run_seq(8'hA4, 0, 1'b1, KEY_B, DAT_A, KEY_B, 1'b0);
        wait_start();
        core_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("done_ignored_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        release_core();

        // Reset in the middle of the key field, then a full sequence
        s0 = start_cnt;
        send_byte(8'hA4, 0);
        for (int i = 0; i < 7; i++) send_byte(KEY_B[127-8*i -: 8], 0);
        do_reset();
        @(negedge clk);
        check("midkey_rst_key", key, '0);
        check("midkey_rst_busy", busy, 1'b0);
        check("midkey_rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        run_seq(8'hA4, 0, 1'b1, KEY_A, DAT_B, KEY_A, 1'b0);
        wait_start();
        check("midkey_one_start", start_cnt - s0, 1);

        // Reset while in WAIT abandons the request
        s0 = start_cnt;
        do_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("wait_rst_busy", busy, 1'b0);
        check("wait_rst_no_start", start_cnt - s0, 0);
        @(posedge clk);
        #1;

`ifdef AES_LOADER_KEY_REUSE_EN
        // Reuse header before any key is an error
        send_byte(8'hA6, 0);
        @(negedge clk);
        check("reuse_nokey_err", err, 1'b1);
        check("reuse_nokey_busy", busy, 1'b0);
        check("reuse_nokey_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        run_seq(8'hA4, 0, 1'b1, KEY_B, DAT_A, KEY_B, 1'b0);
        wait_start();
        release_core();
        s0 = start_cnt;
        run_seq(8'hA7, 0, 1'b0, '0, DAT_B, KEY_B, 1'b1);
        wait_start();
        release_core();
        check("reuse_one_start", start_cnt - s0, 1);
        check("reuse_key_held", key, KEY_B);
`else
        // Reuse headers are plain bad headers in the default build
        s0 = start_cnt;
        send_byte(8'hA6, 0);
        @(negedge clk);
        check("a6_bad_err", err, 1'b1);
        check("a6_bad_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send_byte(8'hA7, 0);
        for (int i = 0; i < 16; i++) send_byte(DAT_B[127-8*i -: 8], 0);
        @(negedge clk);
        check("a7_bad_busy", busy, 1'b0);
        check("a7_no_start", start_cnt - s0, 0);
        @(posedge clk);
        #1;
`endif

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
